// File: rtl/mem_stage.sv
// mem_stage: memory-access stage between E/M and M/WB.
// Local word-addressed DMEM plus a valid/ready NoC path for remote tiles.
module mem_stage #(
    parameter int DMEM_WORDS = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        Result_src_M,
    input  logic        MemW_enable_M,
    input  logic [2:0]  funct3_M,
    input  logic [31:0] ALU_result_M,
    input  logic [31:0] WD_M,
    output logic [31:0] mem_read_M,
    output logic        stall_M,
    output logic        misaligned_M,
    output logic        noc_req_valid,
    input  logic        noc_req_ready,
    output logic        noc_req_we,
    output logic [31:0] noc_req_addr,
    output logic [31:0] noc_req_wdata,
    output logic [3:0]  noc_req_be,
    input  logic        noc_resp_valid,
    input  logic [31:0] noc_resp_data
);

    localparam int IDX_W = $clog2(DMEM_WORDS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DONE
    } state_t;

    state_t state;
    state_t state_nx;

    logic access;
    logic is_b;
    logic is_h;
    logic is_w;
    logic misaligned;
    logic aligned;
    logic remote;
    logic remote_go;
    logic local_wr;

    logic [3:0]       st_be;
    logic [31:0]      st_data;
    logic [IDX_W-1:0] idx;
    logic [31:0]      wr_word;
    logic [31:0]      dmem [DMEM_WORDS];

    logic        req_we_q;
    logic [31:0] req_addr_q;
    logic [31:0] req_wdata_q;
    logic [3:0]  req_be_q;
    logic [31:0] resp_q;

    // Access decode; funct3[1:0] selects size, funct3[2] marks unsigned loads
    assign access     = Result_src_M | MemW_enable_M;
    assign is_w       = funct3_M[1];
    assign is_h       = ~funct3_M[1] & funct3_M[0];
    assign is_b       = ~funct3_M[1] & ~funct3_M[0];
    assign misaligned = access & ((is_h & ALU_result_M[0]) |
                                  (is_w & (|ALU_result_M[1:0])));
    assign aligned    = access & ~misaligned;
    assign remote     = ALU_result_M[31];
    assign remote_go  = aligned & remote;
    assign local_wr   = aligned & ~remote & MemW_enable_M;
    assign idx        = ALU_result_M[IDX_W+1:2];

    assign misaligned_M = misaligned;

    always_comb begin
        st_be   = 4'b0000;
        st_data = WD_M;
        unique case (1'b1)
            is_b: begin
                st_be   = 4'b0001 << ALU_result_M[1:0];
                st_data = {4{WD_M[7:0]}};
            end
            is_h: begin
                st_be   = ALU_result_M[1] ? 4'b1100 : 4'b0011;
                st_data = {2{WD_M[15:0]}};
            end
            is_w: begin
                st_be   = 4'b1111;
                st_data = WD_M;
            end
            default: begin
                st_be   = 4'b0000;
                st_data = WD_M;
            end
        endcase
    end

    function automatic logic [31:0] fmt_load(
        input logic [31:0] word,
        input logic [1:0]  off,
        input logic [2:0]  f3
    );
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = 8'(word >> {off, 3'b000});
        h = off[1] ? word[31:16] : word[15:0];
        unique case (f3[1:0])
            2'b00:   r = f3[2] ? {24'd0, b} : {{24{b[7]}}, b};
            2'b01:   r = f3[2] ? {16'd0, h} : {{16{h[15]}}, h};
            default: r = word;
        endcase
        return r;
    endfunction

    // Byte-lane merge so DMEM is written a whole word at a time
    always_comb begin
        wr_word = dmem[idx];
        for (int i = 0; i < 4; i++) begin
            if (st_be[i]) begin
                wr_word[8*i +: 8] = st_data[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (local_wr) begin
            dmem[idx] <= wr_word;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE: begin
                if (remote_go) begin
                    state_nx = S_REQ;
                end
            end
            S_REQ: begin
                if (noc_req_ready) begin
                    state_nx = req_we_q ? S_DONE : S_WAIT;
                end
            end
            S_WAIT: begin
                if (noc_resp_valid) begin
                    state_nx = S_DONE;
                end
            end
            S_DONE: begin
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    // Request fields are captured once in IDLE and held through REQ
    always_ff @(posedge clk) begin
        if (rst) begin
            req_we_q    <= 1'b0;
            req_addr_q  <= 32'd0;
            req_wdata_q <= 32'd0;
            req_be_q    <= 4'd0;
            resp_q      <= 32'd0;
        end else begin
            if (state == S_IDLE && remote_go) begin
                req_we_q    <= MemW_enable_M;
                req_addr_q  <= ALU_result_M;
                req_wdata_q <= st_data;
                req_be_q    <= st_be;
            end
            if (state == S_WAIT && noc_resp_valid) begin
                resp_q <= noc_resp_data;
            end
        end
    end

    always_comb begin
        noc_req_valid = 1'b0;
        stall_M       = 1'b0;
        unique case (state)
            S_IDLE: begin
                stall_M = remote_go;
            end
            S_REQ: begin
                noc_req_valid = 1'b1;
                stall_M       = 1'b1;
            end
            S_WAIT: begin
                stall_M = 1'b1;
            end
            default: begin
                noc_req_valid = 1'b0;
                stall_M       = 1'b0;
            end
        endcase
    end

    assign noc_req_we    = req_we_q;
    assign noc_req_addr  = req_addr_q;
    assign noc_req_wdata = req_wdata_q;
    assign noc_req_be    = req_be_q;

    // Remote load data is only presented in DONE, from the registered word
    always_comb begin
        mem_read_M = 32'd0;
        if (Result_src_M && aligned) begin
            if (!remote) begin
                mem_read_M = fmt_load(dmem[idx], ALU_result_M[1:0], funct3_M);
            end else if (state == S_DONE) begin
                mem_read_M = fmt_load(resp_q, ALU_result_M[1:0], funct3_M);
            end
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: randomized scoreboard bench for mem_stage.
// Byte-level reference model for DMEM and a scripted NoC responder.
module tb_mem_stage;

    localparam int WORDS  = 256;
    localparam int LBYTES = WORDS * 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        Result_src_M;
    logic        MemW_enable_M;
    logic [2:0]  funct3_M;
    logic [31:0] ALU_result_M;
    logic [31:0] WD_M;
    logic [31:0] mem_read_M;
    logic        stall_M;
    logic        misaligned_M;
    logic        noc_req_valid;
    logic        noc_req_ready;
    logic        noc_req_we;
    logic [31:0] noc_req_addr;
    logic [31:0] noc_req_wdata;
    logic [3:0]  noc_req_be;
    logic        noc_resp_valid;
    logic [31:0] noc_resp_data;

    always #5 clk = ~clk;

    mem_stage #(.DMEM_WORDS(WORDS)) dut (
        .clk           (clk),
        .rst           (rst),
        .Result_src_M  (Result_src_M),
        .MemW_enable_M (MemW_enable_M),
        .funct3_M      (funct3_M),
        .ALU_result_M  (ALU_result_M),
        .WD_M          (WD_M),
        .mem_read_M    (mem_read_M),
        .stall_M       (stall_M),
        .misaligned_M  (misaligned_M),
        .noc_req_valid (noc_req_valid),
        .noc_req_ready (noc_req_ready),
        .noc_req_we    (noc_req_we),
        .noc_req_addr  (noc_req_addr),
        .noc_req_wdata (noc_req_wdata),
        .noc_req_be    (noc_req_be),
        .noc_resp_valid(noc_resp_valid),
        .noc_resp_data (noc_resp_data)
    );

    typedef struct {
        logic [31:0] rd;
        logic        mis;
        int          cyc;
    } exp_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        int          rdy;
        int          rsp;
        logic [31:0] rdata;
    } req_t;

    exp_t       exp_q[$];
    req_t       req_q[$];
    logic [7:0] lmem [LBYTES];
    int         n_checks = 0;
    int         n_fail = 0;
    logic       instr_active = 1'b0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h at %0t",
                     name, act, exp, $time);
        end
    endtask

    function automatic int size_of(input logic [2:0] f3);
        return f3[1] ? 4 : (f3[0] ? 2 : 1);
    endfunction

    function automatic logic [31:0] extend(input logic [31:0] v, input int sz,
                                           input logic uns);
        logic [31:0] mask;
        logic [31:0] r;
        if (sz == 4) return v;
        mask = (32'd1 << (8 * sz)) - 32'd1;
        r = v & mask;
        if (!uns && r[8*sz-1]) r = r | ~mask;
        return r;
    endfunction

    function automatic logic [31:0] local_load(input logic [31:0] a,
                                               input logic [2:0] f3);
        logic [31:0] v;
        int sz;
        sz = size_of(f3);
        v = 32'd0;
        for (int i = 0; i < sz; i++)
            v = v | (32'(lmem[(int'(a[30:0]) + i) % LBYTES]) << (8 * i));
        return extend(v, sz, f3[2]);
    endfunction

    function automatic logic [31:0] remote_load(input logic [31:0] a,
                                                input logic [2:0] f3,
                                                input logic [31:0] raw);
        logic [31:0] v;
        int sz;
        sz = size_of(f3);
        v = 32'd0;
        for (int i = 0; i < sz; i++)
            v = v | (32'(8'(raw >> (8 * (int'(a[1:0]) + i)))) << (8 * i));
        return extend(v, sz, f3[2]);
    endfunction

    task automatic check_req(input req_t r);
        check("req_we", 32'(noc_req_we), 32'(r.we));
        check("req_addr", noc_req_addr, r.addr);
        check("req_be", 32'(noc_req_be), 32'(r.be));
        if (r.we) check("req_wdata", noc_req_wdata, r.wdata);
    endtask

    // Issue one instruction into M and hold it until the stage releases it
    task automatic issue(input logic ld, input logic st, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd,
                         input int rdy, input int rsp, input logic [31:0] rdata,
                         input logic use_k, input logic [31:0] k);
        exp_t e;
        req_t r;
        int   sz;
        int   n;
        logic acc;
        logic mis;
        sz    = size_of(f3);
        acc   = ld | st;
        mis   = acc && ((a % 32'(sz)) != 32'd0);
        e.rd  = 32'd0;
        e.mis = mis;
        e.cyc = 1;
        if (acc && !mis) begin
            if (a[31]) begin
                r.we    = st;
                r.addr  = a;
                r.rdy   = rdy;
                r.rsp   = rsp;
                r.rdata = rdata;
                r.be    = 4'(((32'd1 << sz) - 32'd1) << a[1:0]);
                for (int i = 0; i < 4; i++)
                    r.wdata[8*i +: 8] = wd[8*(i % sz) +: 8];
                req_q.push_back(r);
                e.cyc = st ? rdy + 3 : rdy + rsp + 4;
                if (ld) e.rd = remote_load(a, f3, rdata);
            end else if (ld) begin
                e.rd = local_load(a, f3);
            end else begin
                for (int i = 0; i < sz; i++)
                    lmem[(int'(a[30:0]) + i) % LBYTES] = wd[8*i +: 8];
            end
        end
        if (use_k) e.rd = k;
        exp_q.push_back(e);
        Result_src_M  = ld;
        MemW_enable_M = st;
        funct3_M      = f3;
        ALU_result_M  = a;
        WD_M          = wd;
        instr_active  = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (stall_M && n < 200);
        if (stall_M) begin
            n_fail++;
            $display("FAIL stall_timeout: stall_M still 1 after %0d cycles", n);
            $fatal(1, "stall_M stuck");
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare against the scoreboard whenever M releases an instruction
    initial begin : monitor
        int   cyc;
        exp_t e;
        cyc = 0;
        forever begin
            @(negedge clk);
            if (instr_active) begin
                cyc++;
                if (!stall_M) begin
                    if (exp_q.size() == 0) begin
                        check("exp_underflow", 32'(exp_q.size()), 32'd1);
                    end else begin
                        e = exp_q.pop_front();
                        check("mem_read", mem_read_M, e.rd);
                        check("misaligned", 32'(misaligned_M), 32'(e.mis));
                        check("m_cycles", 32'(cyc), 32'(e.cyc));
                    end
                    cyc = 0;
                end else begin
                    check("stall_read_zero", mem_read_M, 32'd0);
                end
            end
        end
    end

    // Remote tile: scripted backpressure/latency, stray responses when idle
    initial begin : responder
        req_t r;
        noc_req_ready  = 1'b0;
        noc_resp_valid = 1'b0;
        noc_resp_data  = 32'd0;
        forever begin
            @(negedge clk);
            noc_req_ready  = 1'b0;
            noc_resp_valid = 1'b0;
            if (noc_req_valid) begin
                if (req_q.size() == 0) begin
                    check("unexpected_req", 32'(noc_req_valid), 32'd0);
                    noc_req_ready = 1'b1;
                end else begin
                    r = req_q.pop_front();
                    check_req(r);
                    for (int k = 0; k < r.rdy; k++) begin
                        @(negedge clk);
                        check("req_valid_held", 32'(noc_req_valid), 32'd1);
                        check_req(r);
                    end
                    noc_req_ready = 1'b1;
                    if (!r.we) begin
                        @(negedge clk);
                        noc_req_ready = 1'b0;
                        check("req_dropped", 32'(noc_req_valid), 32'd0);
                        for (int k = 0; k < r.rsp; k++) @(negedge clk);
                        noc_resp_valid = 1'b1;
                        noc_resp_data  = r.rdata;
                    end
                end
            end else if ($urandom_range(3) == 0) begin
                noc_resp_valid = 1'b1;
                noc_resp_data  = $urandom;
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        req_t rr;
        int   n;
        rst           = 1'b1;
        Result_src_M  = 1'b0;
        MemW_enable_M = 1'b0;
        funct3_M      = 3'b000;
        ALU_result_M  = 32'd0;
        WD_M          = 32'd0;
        repeat (3) @(negedge clk);
        check("rst_stall", 32'(stall_M), 32'd0);
        check("rst_req_valid", 32'(noc_req_valid), 32'd0);
        check("rst_req_we", 32'(noc_req_we), 32'd0);
        check("rst_req_addr", noc_req_addr, 32'd0);
        check("rst_req_wdata", noc_req_wdata, 32'd0);
        check("rst_req_be", 32'(noc_req_be), 32'd0);
        check("rst_mem_read", mem_read_M, 32'd0);
        check("rst_misaligned", 32'(misaligned_M), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int w = 0; w < WORDS; w++)
            issue(1'b0, 1'b1, 3'b010, 32'(w * 4), $urandom, 0, 0, 32'd0,
                  1'b0, 32'd0);

        issue(1'b0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 0, 0, 0, 1'b1, 32'd0);
        issue(1'b1, 1'b0, 3'b000, 32'h13, 0, 0, 0, 0, 1'b1, 32'hFFFFFFDE);
        issue(1'b1, 1'b0, 3'b100, 32'h13, 0, 0, 0, 0, 1'b1, 32'h000000DE);
        issue(1'b1, 1'b0, 3'b001, 32'h12, 0, 0, 0, 0, 1'b1, 32'hFFFFDEAD);
        issue(1'b1, 1'b0, 3'b010, 32'h10, 0, 0, 0, 0, 1'b1, 32'hDEADBEEF);

        issue(1'b0, 1'b1, 3'b010, 32'h20, 32'h11223344, 0, 0, 0, 1'b1, 32'd0);
        issue(1'b0, 1'b1, 3'b000, 32'h21, 32'h0000005A, 0, 0, 0, 1'b1, 32'd0);
        issue(1'b1, 1'b0, 3'b010, 32'h20, 0, 0, 0, 0, 1'b1, 32'h11225A44);
        issue(1'b0, 1'b1, 3'b001, 32'h22, 32'h0000BEEF, 0, 0, 0, 1'b1, 32'd0);
        issue(1'b1, 1'b0, 3'b010, 32'h20, 0, 0, 0, 0, 1'b1, 32'hBEEF5A44);

        issue(1'b1, 1'b0, 3'b010, 32'h6, 0, 0, 0, 0, 1'b1, 32'd0);
        issue(1'b0, 1'b1, 3'b001, 32'h3, 32'h1234, 0, 0, 0, 1'b1, 32'd0);
        issue(1'b1, 1'b0, 3'b010, 32'h4, 0, 0, 0, 0, 1'b0, 32'd0);
        issue(1'b1, 1'b0, 3'b010, 32'h0, 0, 0, 0, 0, 1'b0, 32'd0);

        issue(1'b1, 1'b0, 3'b001, 32'h80000002, 0, 2, 3, 32'h80011234,
              1'b1, 32'hFFFF8001);
        issue(1'b0, 1'b1, 3'b000, 32'h80000001, 32'h7F, 5, 0, 0, 1'b1, 32'd0);

        // Reset while the stage waits on a remote response
        instr_active  = 1'b0;
        Result_src_M  = 1'b0;
        MemW_enable_M = 1'b0;
        @(posedge clk);
        #1;
        rr.we = 1'b0;  rr.addr = 32'h80000040; rr.wdata = 32'd0;
        rr.be = 4'hF;  rr.rdy = 0; rr.rsp = 2; rr.rdata = 32'h12345678;
        req_q.push_back(rr);
        Result_src_M = 1'b1;
        funct3_M     = 3'b010;
        ALU_result_M = 32'h80000040;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!noc_req_valid && n < 50);
        check("rst_test_req_seen", 32'(noc_req_valid), 32'd1);
        @(posedge clk);
        #1;
        rst          = 1'b1;
        Result_src_M = 1'b0;
        @(negedge clk);
        check("rst_test_wait_stall", 32'(stall_M), 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("rst_test_stall", 32'(stall_M), 32'd0);
            check("rst_test_valid", 32'(noc_req_valid), 32'd0);
            check("rst_test_read", mem_read_M, 32'd0);
        end
        check("rst_test_addr", noc_req_addr, 32'd0);
        check("rst_test_be", 32'(noc_req_be), 32'd0);
        @(posedge clk);
        #1;

        for (int t = 0; t < 400; t++) begin
            int          kind;
            int          sz;
            logic        ld;
            logic        st;
            logic [2:0]  f3;
            logic [31:0] a;
            kind = int'($urandom_range(9));
            ld = 1'b0;
            st = 1'b0;
            if (kind >= 1 && kind <= 5) ld = 1'b1;
            else if (kind > 5) st = 1'b1;
            if (ld) begin
                case ($urandom_range(4))
                    0: f3 = 3'b000;
                    1: f3 = 3'b001;
                    2: f3 = 3'b010;
                    3: f3 = 3'b100;
                    default: f3 = 3'b101;
                endcase
            end else begin
                f3 = 3'($urandom_range(2));
            end
            a = $urandom;
            if ($urandom_range(2) != 0) a[31] = 1'b0;
            sz = size_of(f3);
            if ($urandom_range(3) != 0) a = a & ~32'(sz - 1);
            issue(ld, st, f3, a, $urandom, int'($urandom_range(3)),
                  int'($urandom_range(4)), $urandom, 1'b0, 32'd0);
        end

        instr_active  = 1'b0;
        Result_src_M  = 1'b0;
        MemW_enable_M = 1'b0;
        repeat (3) @(negedge clk);
        check("exp_q_drained", 32'(exp_q.size()), 32'd0);
        check("req_q_drained", 32'(req_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
